// File: rtl/div_seq_arbiter.sv
// div_seq_arbiter: two-port round-robin front end sharing one restoring radix-2 divider
module div_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quot,
    output logic [WIDTH-1:0] resp_rem,
    output logic             resp_dbz
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic last_grant;
    logic idle;
    logic [WIDTH-1:0] acc, dvs, rem, rem_nxt, sel_a, sel_b;
    logic [WIDTH:0] trial;
    logic qbit;
    logic [CW-1:0] cnt;
    assign idle = rst_n && state == IDLE;
    assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
    assign sel_a = req1_ready ? req1_a : req0_a;
    assign sel_b = req1_ready ? req1_b : req0_b;
    // acc shifts the dividend out of its MSB while quotient bits enter at its LSB
    assign trial = {rem, acc[WIDTH-1]};
    assign qbit = trial >= {1'b0, dvs};
    assign rem_nxt = qbit ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= 1'b1;
            acc <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            resp_valid <= 1'b0;
            resp_id <= 1'b0;
            resp_quot <= '0;
            resp_rem <= '0;
            resp_dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    last_grant <= req1_ready;
                    resp_id <= req1_ready;
                    acc <= sel_a;
                    dvs <= sel_b;
                    rem <= '0;
                    cnt <= '0;
                    if (sel_b == '0) begin
                        state <= DONE;
                        resp_valid <= 1'b1;
                        resp_quot <= '1;
                        resp_rem <= sel_a;
                        resp_dbz <= 1'b1;
                    end else begin
                        state <= CALC;
                        resp_dbz <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= {acc[WIDTH-2:0], qbit};
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        resp_valid <= 1'b1;
                        resp_quot <= {acc[WIDTH-2:0], qbit};
                        resp_rem <= rem_nxt;
                    end
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_arbiter.sv
// tb_div_seq_arbiter: directed scenarios plus randomized traffic against an arithmetic reference
module tb_div_seq_arbiter;
    localparam int W = 8;
    localparam int N_RAND = 1500;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, resp_valid, resp_id, resp_dbz;
    logic [W-1:0] resp_quot, resp_rem;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_seq_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dbz(resp_dbz)
    );

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
        tests++;
        if (resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL resp_timeout got resp_valid=%b after %0d cycles want 1", resp_valid, lat);
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_dbz} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000", {req0_ready, req1_ready, resp_valid, resp_id, resp_dbz});
        end
        tests++;
        if ({resp_quot, resp_rem} !== '0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {resp_quot, resp_rem});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd7;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL single_grant got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        #1;
        tests++;
        if (req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_ready_once got %b want 0", req0_ready);
        end
        req0_valid = 1'b0;
        wait_resp(lat);
        tests++;
        if (lat != 9) begin
            fails++;
            $display("FAIL single_latency got %0d want 9", lat);
        end
        tests++;
        if ({resp_id, resp_quot, resp_rem, resp_dbz} !== {1'b0, 8'd28, 8'd4, 1'b0}) begin
            fails++;
            $display("FAIL single_result got id=%0d q=%0d r=%0d dbz=%0d want 0 28 4 0", resp_id, resp_quot, resp_rem, resp_dbz);
        end
        take_resp();
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_release got %b want 0", resp_valid);
        end
    endtask

    task automatic test_dbz();
        int lat;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'd13; req1_b = 8'd0;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            fails++;
            $display("FAIL dbz_grant got %b want 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        #1;
        wait_resp(lat);
        tests++;
        if (req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL dbz_ready_in_done got %b want 0", req1_ready);
        end
        req1_valid = 1'b0;
        tests++;
        if (lat != 1) begin
            fails++;
            $display("FAIL dbz_latency got %0d want 1", lat);
        end
        tests++;
        if ({resp_id, resp_quot, resp_rem, resp_dbz} !== {1'b1, 8'd255, 8'd13, 1'b1}) begin
            fails++;
            $display("FAIL dbz_result got id=%0d q=%0d r=%0d dbz=%0d want 1 255 13 1", resp_id, resp_quot, resp_rem, resp_dbz);
        end
        take_resp();
    endtask

    task automatic test_arb();
        int lat;
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd1;
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd9;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL arb_first got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem, lat} !== {1'b0, 8'd255, 8'd0, 32'd9}) begin
            fails++;
            $display("FAIL arb_res0 got id=%0d q=%0d r=%0d lat=%0d want 0 255 0 9", resp_id, resp_quot, resp_rem, lat);
        end
        req0_valid = 1'b1; req0_a = 8'd17; req0_b = 8'd4;
        take_resp();
        tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            fails++;
            $display("FAIL arb_alternate got %b want 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem} !== {1'b1, 8'd0, 8'd5}) begin
            fails++;
            $display("FAIL arb_res1 got id=%0d q=%0d r=%0d want 1 0 5", resp_id, resp_quot, resp_rem);
        end
        take_resp();
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL arb_lone got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem} !== {1'b0, 8'd4, 8'd1}) begin
            fails++;
            $display("FAIL arb_res2 got id=%0d q=%0d r=%0d want 0 4 1", resp_id, resp_quot, resp_rem);
        end
        take_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd10;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_resp(lat);
        req0_valid = 1'b1; req0_a = 8'd50; req0_b = 8'd5;
        req1_valid = 1'b1; req1_a = 8'd60; req1_b = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({resp_valid, resp_id, resp_quot, resp_rem, resp_dbz, req1_ready, req0_ready} !== {1'b1, 1'b0, 8'd10, 8'd0, 1'b0, 2'b00}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got v=%b id=%0d q=%0d r=%0d rdy=%b want 1 0 10 0 00", i, resp_valid, resp_id, resp_quot, resp_rem, {req1_ready, req0_ready});
            end
        end
        take_resp();
        tests++;
        if ({resp_valid, req1_ready, req0_ready} !== 3'b010) begin
            fails++;
            $display("FAIL bp_regrant got v=%b rdy=%b want 0 10", resp_valid, {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem, lat} !== {1'b1, 8'd8, 8'd4, 32'd9}) begin
            fails++;
            $display("FAIL bp_res1 got id=%0d q=%0d r=%0d lat=%0d want 1 8 4 9", resp_id, resp_quot, resp_rem, lat);
        end
        take_resp();
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem} !== {1'b0, 8'd10, 8'd0}) begin
            fails++;
            $display("FAIL bp_res0 got id=%0d q=%0d r=%0d want 0 10 0", resp_id, resp_quot, resp_rem);
        end
        take_resp();
    endtask

    task automatic test_async_reset();
        int lat;
        int stale;
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd128; req0_b = 8'd3;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({resp_valid, req1_ready, req0_ready, resp_quot, resp_rem} !== '0) begin
            fails++;
            $display("FAIL areset_calc got v=%b q=%0d r=%0d want 0 0 0", resp_valid, resp_quot, resp_rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL areset_stale got %0d valid cycles want 0", stale);
        end
        req0_valid = 1'b1; req0_a = 8'd128; req0_b = 8'd3;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem, lat} !== {1'b0, 8'd42, 8'd2, 32'd9}) begin
            fails++;
            $display("FAIL areset_redo got id=%0d q=%0d r=%0d lat=%0d want 0 42 2 9", resp_id, resp_quot, resp_rem, lat);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({resp_valid, resp_quot, resp_rem} !== '0) begin
            fails++;
            $display("FAIL areset_done got v=%b q=%0d r=%0d want 0 0 0", resp_valid, resp_quot, resp_rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd4;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL areset_tie got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        wait_resp(lat);
        tests++;
        if ({resp_id, resp_quot, resp_rem} !== {1'b0, 8'd4, 8'd1}) begin
            fails++;
            $display("FAIL areset_tie_res got id=%0d q=%0d r=%0d want 0 4 1", resp_id, resp_quot, resp_rem);
        end
        take_resp();
    endtask

    task automatic test_random();
        logic [2*W+1:0] exp_q[$];
        logic [2*W+1:0] got, want;
        logic [1:0] exp_rdy;
        bit lg, busy, g0, g1;
        int issued, done, cyc;
        lg = 1'b1; busy = 1'b0; g0 = 1'b0; g1 = 1'b0;
        issued = 0; done = 0; cyc = 0;
        apply_reset();
        while (done < N_RAND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
            if (!req0_valid && issued < N_RAND && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_a = W'($urandom);
                req0_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom) >> $urandom_range(0, W - 1);
                issued++;
            end
            if (!req1_valid && issued < N_RAND && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_a = W'($urandom);
                req1_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom) >> $urandom_range(0, W - 1);
                issued++;
            end
            resp_ready = ($urandom_range(0, 1) == 1);
            #1;
            exp_rdy = busy ? 2'b00 : (req0_valid && req1_valid) ? (lg ? 2'b01 : 2'b10) : {req1_valid, req0_valid};
            tests++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                fails++;
                $display("FAIL rand_grant cycle %0d got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy);
            end
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (g0 || g1) begin
                busy = 1'b1;
                lg = g1;
                exp_q.push_back(g1 ? {1'b1, ref_q(req1_a, req1_b), ref_r(req1_a, req1_b), req1_b == '0}
                                   : {1'b0, ref_q(req0_a, req0_b), ref_r(req0_a, req0_b), req0_b == '0});
            end
            if (resp_valid && resp_ready) begin
                tests++;
                got = {resp_id, resp_quot, resp_rem, resp_dbz};
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_spurious got %h want no response", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        fails++;
                        $display("FAIL rand_result cycle %0d got id/q/r/dbz %h want %h", cyc, got, want);
                    end
                end
                busy = 1'b0;
                done++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        tests++;
        if (done != N_RAND) begin
            fails++;
            $display("FAIL rand_complete got %0d responses want %0d", done, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_arb();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
